// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEF    = 64;
  localparam int INSTR_W_DEF   = 32;
  localparam int BUF_DEPTH_DEF = 2;
  localparam int CNT_W         = $clog2(BUF_DEPTH_DEF + 1);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, credit-limited memory requests, response
// buffering and redirect handling with discard of in-flight responses.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PC_STEP   = 4,
  parameter int                BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ImemReqValid,
  input  logic               ImemReqReady,
  output logic [ADDR_W-1:0]  ImemAddr,
  input  logic               ImemRspValid,
  input  logic [INSTR_W-1:0] ImemRspData,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic [ADDR_W-1:0]  InstrPCPlus
);

  localparam int                CW   = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic              empty;
  logic              full;
  logic              req_fire;
  logic              rsp_ok;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  // Every buffered word and every in-flight request holds one slot.
  assign credit_used  = {1'b0, outstanding} + {1'b0, count};
  assign ImemReqValid = rst_n && (credit_used < (CW+1)'(BUF_DEPTH)) && !Redirect;
  assign ImemAddr     = pc;
  assign req_fire     = ImemReqValid && ImemReqReady;

  assign rsp_ok          = ImemRspValid && (outstanding != '0);
  assign push            = rsp_ok && (drop == '0) && !Redirect;
  assign pop             = !empty && InstrReady;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_ok);
  assign push_data       = '{pc: rsp_pc, instr: ImemRspData};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (Redirect) begin
        pc     <= RedirectPC;
        rsp_pc <= RedirectPC;
        // Everything still in flight after this cycle belongs to the old path.
        drop   <= outstanding_nxt;
      end else begin
        if (req_fire) pc <= pc + STEP;
        if (push) rsp_pc <= rsp_pc + STEP;
        if (rsp_ok && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (Redirect),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign InstrValid  = !empty;
  assign Instruction = empty ? '0 : head.instr;
  assign InstrPC     = empty ? '0 : head.pc;
  assign InstrPCPlus = empty ? '0 : head.pc + STEP;

  rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
    ImemRspValid |-> (outstanding != '0));
  credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= (CW+1)'(BUF_DEPTH));
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && full) |-> pop);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory model of configurable latency.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ImemReqValid;
  logic        ImemReqReady = 1'b1;
  logic [63:0] ImemAddr;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = '0;
  logic        Redirect = 1'b0;
  logic [63:0] RedirectPC = '0;
  logic        InstrValid;
  logic        InstrReady = 1'b1;
  logic [31:0] Instruction;
  logic [63:0] InstrPC;
  logic [63:0] InstrPCPlus;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instruction(Instruction),
    .InstrPC(InstrPC), .InstrPCPlus(InstrPCPlus)
  );

  typedef struct { int unsigned due; logic [63:0] addr; } mreq_t;
  typedef struct { logic [63:0] pc; logic [63:0] plus; logic [31:0] instr; } dec_t;

  mreq_t       mq[$];
  logic [63:0] hs_log[$];
  dec_t        got[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;
  int          n_checks = 0;
  int          n_fail = 0;

  // Memory: word returned for address A is A[31:0] ^ 32'hDEAD0000.
  initial begin : mem_model
    forever begin
      @(posedge clk);
      if (!rst_n) mq.delete();
      else if (ImemReqValid && ImemReqReady) begin
        mq.push_back('{cyc + mem_lat, ImemAddr});
        hs_log.push_back(ImemAddr);
      end
      cyc++;
      #1;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        ImemRspValid = 1'b1;
        ImemRspData  = mq[0].addr[31:0] ^ 32'hDEAD0000;
        void'(mq.pop_front());
      end else begin
        ImemRspValid = 1'b0;
        ImemRspData  = '0;
      end
    end
  end

  initial begin : dec_monitor
    forever begin
      @(negedge clk);
      if (rst_n && InstrValid && InstrReady)
        got.push_back('{InstrPC, InstrPCPlus, Instruction});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int unsigned lat);
    rst_n = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    ImemReqReady = 1'b1; InstrReady = 1'b1; mem_lat = lat;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    got.delete();
    hs_log.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    n_checks++; if (ImemReqValid !== 1'b0) begin n_fail++; $display("FAIL reset_reqvalid: got %b expected 0", ImemReqValid); end
    n_checks++; if (ImemAddr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", ImemAddr); end
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL reset_instrvalid: got %b expected 0", InstrValid); end
    n_checks++; if ({Instruction, InstrPC, InstrPCPlus} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h/%h/%h expected 0", Instruction, InstrPC, InstrPCPlus); end
  endtask

  task automatic test_sequential();
    do_reset(1);
    @(negedge clk);
    n_checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 64'h0) begin n_fail++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=0", ImemReqValid, ImemAddr); end
    repeat (20) step();
    n_checks++;
    if (got.size() < 6) begin n_fail++; $display("FAIL seq_count: got %0d expected >=6", got.size()); end
    else for (int i = 0; i < 6; i++) begin
      logic [63:0] e; e = 64'(i * 4);
      n_checks++; if (got[i].pc !== e || got[i].plus !== e + 64'd4 || got[i].instr !== (e[31:0] ^ 32'hDEAD0000)) begin
        n_fail++; $display("FAIL seq_entry%0d: got pc=%h plus=%h instr=%h expected pc=%h", i, got[i].pc, got[i].plus, got[i].instr, e);
      end
    end
    n_checks++;
    if (hs_log.size() < 3 || hs_log[0] !== 64'h0 || hs_log[1] !== 64'h4 || hs_log[2] !== 64'h8) begin
      n_fail++; $display("FAIL seq_req_addrs: got %0d requests expected 0,4,8 first", hs_log.size());
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    InstrReady = 1'b0;
    repeat (10) step();
    @(negedge clk);
    n_checks++; if (ImemReqValid !== 1'b0) begin n_fail++; $display("FAIL stall_reqvalid: got %b expected 0", ImemReqValid); end
    n_checks++; if (InstrValid !== 1'b1 || InstrPC !== 64'h0) begin n_fail++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=0", InstrValid, InstrPC); end
    n_checks++; if (dut.count !== 2'd2) begin n_fail++; $display("FAIL stall_count: got %0d expected 2", dut.count); end
    step();
    InstrReady = 1'b1;
    repeat (20) step();
    n_checks++;
    if (got.size() < 6) begin n_fail++; $display("FAIL stall_release_count: got %0d expected >=6", got.size()); end
    else for (int i = 0; i < 6; i++) begin
      n_checks++; if (got[i].pc !== 64'(i * 4)) begin n_fail++; $display("FAIL stall_order%0d: got %h expected %h", i, got[i].pc, 64'(i * 4)); end
    end
  endtask

  task automatic test_redirect();
    int stale;
    do_reset(3);
    step(); step();
    Redirect = 1'b1; RedirectPC = 64'h1000;
    @(negedge clk);
    n_checks++; if (dut.outstanding !== 2'd2) begin n_fail++; $display("FAIL redir_outstanding: got %0d expected 2", dut.outstanding); end
    n_checks++; if (ImemReqValid !== 1'b0) begin n_fail++; $display("FAIL redir_reqvalid: got %b expected 0", ImemReqValid); end
    step();
    Redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (ImemAddr !== 64'h1000) begin n_fail++; $display("FAIL redir_addr: got %h expected 1000", ImemAddr); end
    repeat (20) step();
    stale = 0;
    foreach (got[i]) if (got[i].pc < 64'h1000) stale++;
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL redir_stale: got %0d stale entries expected 0", stale); end
    n_checks++;
    if (got.size() < 2) begin n_fail++; $display("FAIL redir_count: got %0d expected >=2", got.size()); end
    else begin
      n_checks++; if (got[0].pc !== 64'h1000 || got[0].instr !== 32'hDEAD1000) begin n_fail++; $display("FAIL redir_first: got pc=%h instr=%h expected 1000/dead1000", got[0].pc, got[0].instr); end
      n_checks++; if (got[1].pc !== 64'h1004) begin n_fail++; $display("FAIL redir_second: got %h expected 1004", got[1].pc); end
    end
  endtask

  task automatic test_redirect_rsp();
    int stale;
    do_reset(1);
    step();
    Redirect = 1'b1; RedirectPC = 64'h2000; ImemReqReady = 1'b1;
    @(negedge clk);
    n_checks++; if (ImemReqValid !== 1'b0) begin n_fail++; $display("FAIL rr_reqvalid: got %b expected 0", ImemReqValid); end
    step();
    Redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (ImemAddr !== 64'h2000 || ImemReqValid !== 1'b1) begin n_fail++; $display("FAIL rr_addr: got v=%b a=%h expected v=1 a=2000", ImemReqValid, ImemAddr); end
    n_checks++; if (dut.drop !== 2'd0) begin n_fail++; $display("FAIL rr_drop: got %0d expected 0", dut.drop); end
    repeat (10) step();
    stale = 0;
    foreach (got[i]) if (got[i].pc < 64'h2000) stale++;
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rr_stale: got %0d expected 0", stale); end
    n_checks++;
    if (got.size() < 2) begin n_fail++; $display("FAIL rr_count: got %0d expected >=2", got.size()); end
    else begin
      n_checks++; if (got[0].pc !== 64'h2000 || got[1].pc !== 64'h2004) begin n_fail++; $display("FAIL rr_seq: got %h,%h expected 2000,2004", got[0].pc, got[1].pc); end
    end
  endtask

  task automatic test_back_to_back();
    int stale;
    do_reset(3);
    step();
    Redirect = 1'b1; RedirectPC = 64'h2000;
    step();
    RedirectPC = 64'h3000;
    @(negedge clk);
    n_checks++; if (dut.drop !== 2'd1) begin n_fail++; $display("FAIL b2b_drop1: got %0d expected 1", dut.drop); end
    step();
    Redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (ImemAddr !== 64'h3000 || ImemReqValid !== 1'b1) begin n_fail++; $display("FAIL b2b_addr: got v=%b a=%h expected v=1 a=3000", ImemReqValid, ImemAddr); end
    n_checks++; if (dut.drop !== 2'd1) begin n_fail++; $display("FAIL b2b_drop2: got %0d expected 1", dut.drop); end
    repeat (15) step();
    stale = 0;
    foreach (got[i]) if (got[i].pc < 64'h3000) stale++;
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL b2b_stale: got %0d expected 0", stale); end
    n_checks++;
    if (got.size() < 1) begin n_fail++; $display("FAIL b2b_count: got %0d expected >=1", got.size()); end
    else begin
      n_checks++; if (got[0].pc !== 64'h3000) begin n_fail++; $display("FAIL b2b_first: got %h expected 3000", got[0].pc); end
    end
  endtask

  task automatic test_flush_pop();
    do_reset(1);
    InstrReady = 1'b0;
    repeat (5) step();
    Redirect = 1'b1; RedirectPC = 64'h4000; InstrReady = 1'b1;
    @(negedge clk);
    n_checks++; if (InstrValid !== 1'b1 || InstrPC !== 64'h0) begin n_fail++; $display("FAIL fp_head: got v=%b pc=%h expected v=1 pc=0", InstrValid, InstrPC); end
    step();
    Redirect = 1'b0;
    @(negedge clk);
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL fp_flushed: got %b expected 0", InstrValid); end
    repeat (10) step();
    n_checks++;
    if (got.size() < 3) begin n_fail++; $display("FAIL fp_count: got %0d expected >=3", got.size()); end
    else begin
      n_checks++; if (got[0].pc !== 64'h0 || got[1].pc !== 64'h4000 || got[2].pc !== 64'h4004) begin
        n_fail++; $display("FAIL fp_seq: got %h,%h,%h expected 0,4000,4004", got[0].pc, got[1].pc, got[2].pc);
      end
    end
  endtask

  task automatic test_req_stall();
    do_reset(1);
    ImemReqReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 64'h0) begin n_fail++; $display("FAIL rs_hold%0d: got v=%b a=%h expected v=1 a=0", i, ImemReqValid, ImemAddr); end
      step();
    end
    ImemReqReady = 1'b1;
    repeat (10) step();
    n_checks++;
    if (hs_log.size() < 3 || hs_log[0] !== 64'h0 || hs_log[1] !== 64'h4 || hs_log[2] !== 64'h8) begin
      n_fail++; $display("FAIL rs_addrs: got %0d requests expected 0,4,8 first", hs_log.size());
    end
    n_checks++; if (got.size() < 1 || got[0].pc !== 64'h0) begin n_fail++; $display("FAIL rs_first: got %0d entries expected first pc 0", got.size()); end
  endtask

  task automatic test_reset_midstream();
    do_reset(1);
    InstrReady = 1'b0;
    repeat (6) step();
    @(negedge clk);
    n_checks++; if (InstrValid !== 1'b1 || dut.count !== 2'd2) begin n_fail++; $display("FAIL mr_full: got v=%b cnt=%0d expected v=1 cnt=2", InstrValid, dut.count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0) begin n_fail++; $display("FAIL mr_valids: got req=%b instr=%b expected 0,0", ImemReqValid, InstrValid); end
    n_checks++; if ({ImemAddr, Instruction, InstrPC, InstrPCPlus} !== '0) begin n_fail++; $display("FAIL mr_outputs: got %h/%h/%h/%h expected 0", ImemAddr, Instruction, InstrPC, InstrPCPlus); end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; InstrReady = 1'b1;
    got.delete(); hs_log.delete();
    @(negedge clk);
    n_checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 64'h0) begin n_fail++; $display("FAIL mr_restart: got v=%b a=%h expected v=1 a=0", ImemReqValid, ImemAddr); end
    repeat (10) step();
    n_checks++; if (got.size() < 2 || got[0].pc !== 64'h0 || got[1].pc !== 64'h4) begin n_fail++; $display("FAIL mr_seq: got %0d entries expected 0,4 first", got.size()); end
  endtask

  initial begin : main
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_back_to_back();
    test_flush_pop();
    test_req_stall();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
